// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states, default DMem index width.
package lsu_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } lsuState_t;

  // Size code 11 behaves as a full word, so only the upper bit matters.
  function automatic logic isWordSize(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// Byte-lane helper: extracts/extends load data and merges sub-word store data into a memory word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        isUnsigned,
  input  logic [1:0]  byteOff,
  input  logic [31:0] memWord,
  input  logic [31:0] storeData,
  output logic [31:0] loadData_c,
  output logic [31:0] mergedWord_c
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic        unusedStore_c;

  // Upper store bits only matter for full-word stores, which bypass this merge.
  assign unusedStore_c = ^storeData[31:16];

  // Select the addressed byte and half from the memory word.
  always_comb begin
    byteSel = memWord[7:0];
    case (byteOff)
      2'd0:    byteSel = memWord[7:0];
      2'd1:    byteSel = memWord[15:8];
      2'd2:    byteSel = memWord[23:16];
      default: byteSel = memWord[31:24];
    endcase
    halfSel = byteOff[1] ? memWord[31:16] : memWord[15:0];
  end

  // Extend the selected lane(s) to 32 bits; word loads pass through.
  always_comb begin
    loadData_c = memWord;
    if (size == SZ_BYTE) begin
      loadData_c = {{24{~isUnsigned & byteSel[7]}}, byteSel};
    end else if (size == SZ_HALF) begin
      loadData_c = {{16{~isUnsigned & halfSel[15]}}, halfSel};
    end
  end

  // Replace only the addressed lane(s); other bytes keep their read values.
  always_comb begin
    mergedWord_c = storeData;
    if (size == SZ_BYTE) begin
      mergedWord_c = memWord;
      case (byteOff)
        2'd0:    mergedWord_c[7:0]   = storeData[7:0];
        2'd1:    mergedWord_c[15:8]  = storeData[7:0];
        2'd2:    mergedWord_c[23:16] = storeData[7:0];
        default: mergedWord_c[31:24] = storeData[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      mergedWord_c = memWord;
      if (byteOff[1]) mergedWord_c[31:16] = storeData[15:0];
      else            mergedWord_c[15:0]  = storeData[15:0];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-addressed DMem, sub-word stores via read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses finish immediately with ErrOut.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
)
(
  input  logic              clkIn,
  input  logic              resetIn,
  input  logic              ReqIn,
  input  logic              WeIn,
  input  logic [1:0]        SizeIn,
  input  logic              UnsignedIn,
  input  logic [31:0]       AddrIn,
  input  logic [31:0]       WDataIn,
  input  logic [31:0]       MemDataIn,
  output logic [ADDR_W-1:0] MemAddrOut,
  output logic [31:0]       MemDataOut,
  output logic              MemReadOut,
  output logic              MemWriteOut,
  output logic              BusyOut,
  output logic              DoneOut,
  output logic [31:0]       RDataOut,
  output logic              ErrOut
);

  localparam int unsigned CAP_W = ADDR_W + 2;

  lsuState_t         state, stateNext;
  logic              reqWe, reqWeNext;
  logic [1:0]        reqSize, reqSizeNext;
  logic              reqUns, reqUnsNext;
  logic [CAP_W-1:0]  reqAddr, reqAddrNext;
  logic [31:0]       reqWData, reqWDataNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic [31:0]       memDataNext;
  logic              memReadNext, memWriteNext;
  logic              busyNext, doneNext, errNext;
  logic [31:0]       rDataNext;
  logic [31:0]       loadData_c, mergedWord_c;
  logic              misalign_c;
  logic              unusedAddr_c;

  // Address bits above the word index never reach memory.
  assign unusedAddr_c = ^AddrIn[31:CAP_W];

  // Misalignment detection on the incoming request.
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_c = ((SizeIn == SZ_HALF) && AddrIn[0]) ||
                      (isWordSize(SizeIn) && (AddrIn[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  lsu_lane uLane (
    .size         (reqSize),
    .isUnsigned   (reqUns),
    .byteOff      (reqAddr[1:0]),
    .memWord      (MemDataIn),
    .storeData    (reqWData),
    .loadData_c   (loadData_c),
    .mergedWord_c (mergedWord_c)
  );

  // Next-state and next-output logic; strobes and address default to idle values.
  always_comb begin
    stateNext    = state;
    reqWeNext    = reqWe;
    reqSizeNext  = reqSize;
    reqUnsNext   = reqUns;
    reqAddrNext  = reqAddr;
    reqWDataNext = reqWData;
    memAddrNext  = '0;
    memDataNext  = '0;
    memReadNext  = 1'b0;
    memWriteNext = 1'b0;
    doneNext     = 1'b0;
    errNext      = 1'b0;
    rDataNext    = RDataOut;

    case (state)
      IDLE: begin
        if (ReqIn) begin
          reqWeNext    = WeIn;
          reqSizeNext  = SizeIn;
          reqUnsNext   = UnsignedIn;
          reqAddrNext  = AddrIn[CAP_W-1:0];
          reqWDataNext = WDataIn;
          if (misalign_c) begin
            stateNext = DONE;
            doneNext  = 1'b1;
            errNext   = 1'b1;
          end else if (WeIn && isWordSize(SizeIn)) begin
            stateNext    = WR;
            memWriteNext = 1'b1;
            memAddrNext  = AddrIn[CAP_W-1:2];
            memDataNext  = WDataIn;
          end else begin
            stateNext   = RD;
            memReadNext = 1'b1;
            memAddrNext = AddrIn[CAP_W-1:2];
          end
        end
      end
      RD: begin
        if (reqWe) begin
          stateNext    = WR;
          memWriteNext = 1'b1;
          memAddrNext  = reqAddr[CAP_W-1:2];
          memDataNext  = mergedWord_c;
        end else begin
          stateNext = DONE;
          doneNext  = 1'b1;
          rDataNext = loadData_c;
        end
      end
      WR: begin
        stateNext = DONE;
        doneNext  = 1'b1;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    busyNext = (stateNext != IDLE);
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      state       <= IDLE;
      reqWe       <= 1'b0;
      reqSize     <= '0;
      reqUns      <= 1'b0;
      reqAddr     <= '0;
      reqWData    <= '0;
      MemAddrOut  <= '0;
      MemDataOut  <= '0;
      MemReadOut  <= 1'b0;
      MemWriteOut <= 1'b0;
      BusyOut     <= 1'b0;
      DoneOut     <= 1'b0;
      RDataOut    <= '0;
      ErrOut      <= 1'b0;
    end else begin
      state       <= stateNext;
      reqWe       <= reqWeNext;
      reqSize     <= reqSizeNext;
      reqUns      <= reqUnsNext;
      reqAddr     <= reqAddrNext;
      reqWData    <= reqWDataNext;
      MemAddrOut  <= memAddrNext;
      MemDataOut  <= memDataNext;
      MemReadOut  <= memReadNext;
      MemWriteOut <= memWriteNext;
      BusyOut     <= busyNext;
      DoneOut     <= doneNext;
      RDataOut    <= rDataNext;
      ErrOut      <= errNext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, corner sequences, random ops vs. a word-array model.
module tb_load_store_unit;

  localparam int unsigned MEM_WORDS = 32;

  logic        clkIn;
  logic        resetIn;
  logic        ReqIn;
  logic        WeIn;
  logic [1:0]  SizeIn;
  logic        UnsignedIn;
  logic [31:0] AddrIn;
  logic [31:0] WDataIn;
  logic [31:0] MemDataIn;
  logic [4:0]  MemAddrOut;
  logic [31:0] MemDataOut;
  logic        MemReadOut;
  logic        MemWriteOut;
  logic        BusyOut;
  logic        DoneOut;
  logic [31:0] RDataOut;
  logic        ErrOut;

  logic [31:0] mem    [MEM_WORDS];
  logic [31:0] refMem [MEM_WORDS];

  int nChecks = 0;
  int nFails  = 0;

  load_store_unit #(.ADDR_W(5)) dut (
    .clkIn       (clkIn),
    .resetIn     (resetIn),
    .ReqIn       (ReqIn),
    .WeIn        (WeIn),
    .SizeIn      (SizeIn),
    .UnsignedIn  (UnsignedIn),
    .AddrIn      (AddrIn),
    .WDataIn     (WDataIn),
    .MemDataIn   (MemDataIn),
    .MemAddrOut  (MemAddrOut),
    .MemDataOut  (MemDataOut),
    .MemReadOut  (MemReadOut),
    .MemWriteOut (MemWriteOut),
    .BusyOut     (BusyOut),
    .DoneOut     (DoneOut),
    .RDataOut    (RDataOut),
    .ErrOut      (ErrOut)
  );

  initial begin
    clkIn = 1'b0;
    forever #5 clkIn = ~clkIn;
  end

  function automatic logic [31:0] initWord(input int i);
    return (32'(i) * 32'h01030507) ^ 32'h5A5A0000;
  endfunction

  // DMem: combinational read, write on the rising edge.
  assign MemDataIn = MemReadOut ? mem[MemAddrOut] : 32'h0;
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = initWord(i);
    forever begin
      @(posedge clkIn);
      if (MemWriteOut) mem[MemAddrOut] <= MemDataOut;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic mdlTrap(input logic [1:0] size, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    if (size == 2'd1) return (addr % 2) != 0;
    if (size >= 2'd2) return (addr % 4) != 0;
    return 1'b0;
`else
    return (size == 2'd3) && (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic int mdlIdx(input logic [31:0] addr);
    return int'((addr / 4) % MEM_WORDS);
  endfunction

  function automatic logic [31:0] mdlLoad(input logic [31:0] word, input logic [1:0] size,
                                          input logic uns, input logic [31:0] addr);
    int unsigned off;
    logic [31:0] v;
    if (size == 2'd0) begin
      off = addr % 4;
      v = (word >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      off = ((addr % 4) / 2) * 2;
      v = (word >> (8 * off)) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] mdlStore(input logic [31:0] word, input logic [1:0] size,
                                           input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned off;
    logic [31:0] mask;
    if (size >= 2'd2) return wdata;
    off  = (size == 2'd0) ? (addr % 4) : ((addr % 4) / 2) * 2;
    mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
    return (word & ~mask) | ((wdata << (8 * off)) & mask);
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request from IDLE and observe it through completion plus one cycle.
  task automatic runOp(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output int reads, output int writes,
                       output logic err, output logic busyOk, output logic [31:0] rdata,
                       output logic cleanAfter);
    WeIn = we; SizeIn = size; UnsignedIn = uns; AddrIn = addr; WDataIn = wdata; ReqIn = 1'b1;
    tick();
    ReqIn = 1'b0;
    lat = 1; reads = 0; writes = 0; busyOk = 1'b1;
    while (!DoneOut && lat < 16) begin
      reads  += int'(MemReadOut);
      writes += int'(MemWriteOut);
      if (!BusyOut) busyOk = 1'b0;
      tick();
      lat++;
    end
    reads  += int'(MemReadOut);
    writes += int'(MemWriteOut);
    if (!BusyOut) busyOk = 1'b0;
    err   = ErrOut;
    rdata = RDataOut;
    tick();
    cleanAfter = !DoneOut && !BusyOut && !ErrOut && !MemReadOut && !MemWriteOut;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          reads;
    int          writes;
    int          memIdx;
    logic [31:0] memWord;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, reads, writes, accepted, doneCnt, wrCnt;
    logic err, busyOk, clean;
    logic [31:0] rdata, lastR, expR;
    logic we, uns;
    logic [1:0] size;
    logic [31:0] addr, wdata;
    logic trap;
    int idx, expLat, expReads, expWrites;

    for (int i = 0; i < MEM_WORDS; i++) refMem[i] = initWord(i);

    resetIn = 1'b1; ReqIn = 1'b0; WeIn = 1'b0; SizeIn = 2'd0; UnsignedIn = 1'b0;
    AddrIn = 32'h0; WDataIn = 32'h0;
    #12;
    check("reset outputs", 32'(MemAddrOut) | MemDataOut | RDataOut |
          32'({MemReadOut, MemWriteOut, BusyOut, DoneOut, ErrOut}), 32'h0);
    resetIn = 1'b0;
    tick();

    // ---- directed vector table ----
    //          we    size   uns   addr   wdata          lat rdata          err   rd wr idx word
    vecs[0] = '{1'b1, 2'd2, 1'b0, 32'h04, 32'h11223344, 2, 32'h0,        1'b0, 0, 1, 1, 32'h11223344};
    vecs[1] = '{1'b1, 2'd2, 1'b0, 32'h08, 32'h8899AABB, 2, 32'h0,        1'b0, 0, 1, 2, 32'h8899AABB};
    vecs[2] = '{1'b0, 2'd0, 1'b0, 32'h0B, 32'h0,        2, 32'hFFFFFF88, 1'b0, 1, 0, -1, 32'h0};
    vecs[3] = '{1'b0, 2'd0, 1'b1, 32'h0B, 32'h0,        2, 32'h00000088, 1'b0, 1, 0, -1, 32'h0};
    vecs[4] = '{1'b0, 2'd1, 1'b0, 32'h08, 32'h0,        2, 32'hFFFFAABB, 1'b0, 1, 0, -1, 32'h0};
    vecs[5] = '{1'b0, 2'd1, 1'b1, 32'h0A, 32'h0,        2, 32'h00008899, 1'b0, 1, 0, -1, 32'h0};
    vecs[6] = '{1'b1, 2'd0, 1'b0, 32'h09, 32'h1234565A, 3, 32'h00008899, 1'b0, 1, 1, 2, 32'h88995ABB};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[7] = '{1'b0, 2'd2, 1'b0, 32'h06, 32'h0,        1, 32'h00008899, 1'b1, 0, 0, -1, 32'h0};
`else
    vecs[7] = '{1'b0, 2'd2, 1'b0, 32'h06, 32'h0,        2, 32'h11223344, 1'b0, 1, 0, -1, 32'h0};
`endif

    for (int v = 0; v < 8; v++) begin
      runOp(vecs[v].we, vecs[v].size, vecs[v].uns, vecs[v].addr, vecs[v].wdata,
            lat, reads, writes, err, busyOk, rdata, clean);
      check($sformatf("vec%0d latency", v), 32'(lat), 32'(vecs[v].lat));
      check($sformatf("vec%0d rdata", v), rdata, vecs[v].rdata);
      check($sformatf("vec%0d err", v), 32'(err), 32'(vecs[v].err));
      check($sformatf("vec%0d reads", v), 32'(reads), 32'(vecs[v].reads));
      check($sformatf("vec%0d writes", v), 32'(writes), 32'(vecs[v].writes));
      check($sformatf("vec%0d busy", v), 32'(busyOk), 32'h1);
      check($sformatf("vec%0d idle after done", v), 32'(clean), 32'h1);
      if (vecs[v].memIdx >= 0) begin
        check($sformatf("vec%0d mem word", v), mem[vecs[v].memIdx], vecs[v].memWord);
        refMem[vecs[v].memIdx] = vecs[v].memWord;
      end
    end

    // ---- ReqIn held through a word store: exactly two accepts ----
    WeIn = 1'b1; SizeIn = 2'd2; UnsignedIn = 1'b0; AddrIn = 32'h10; WDataIn = 32'hDEADBEEF;
    ReqIn = 1'b1;
    accepted = 0; doneCnt = 0; wrCnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      wrCnt   += int'(MemWriteOut);
      doneCnt += int'(DoneOut);
    end
    ReqIn = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      wrCnt   += int'(MemWriteOut);
      doneCnt += int'(DoneOut);
    end
    accepted = wrCnt;
    check("held req write strobes", 32'(accepted), 32'd2);
    check("held req done pulses", 32'(doneCnt), 32'd2);
    check("held req mem word", mem[4], 32'hDEADBEEF);
    refMem[4] = 32'hDEADBEEF;

    // ---- async reset during the write phase of a half store ----
    WeIn = 1'b1; SizeIn = 2'd1; UnsignedIn = 1'b0; AddrIn = 32'h0A; WDataIn = 32'h0000CAFE;
    ReqIn = 1'b1;
    tick();
    ReqIn = 1'b0;
    check("rmw read phase strobe", 32'(MemReadOut), 32'h1);
    tick();
    check("rmw write phase strobe", 32'(MemWriteOut), 32'h1);
    check("rmw merged data", MemDataOut, 32'hCAFE5ABB);
    #2 resetIn = 1'b1;
    #1;
    check("reset drops write strobe", 32'(MemWriteOut), 32'h0);
    check("reset clears outputs", 32'(MemAddrOut) | MemDataOut | RDataOut |
          32'({MemReadOut, MemWriteOut, BusyOut, DoneOut, ErrOut}), 32'h0);
    #1 resetIn = 1'b0;
    doneCnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      doneCnt += int'(DoneOut) + int'(BusyOut);
    end
    check("no completion after reset", 32'(doneCnt), 32'h0);
    check("aborted store left memory", mem[2], refMem[2]);
    lastR = 32'h0;

    // ---- random operations against the model ----
    for (int n = 0; n < 300; n++) begin
      we    = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      uns   = 1'($urandom_range(0, 1));
      addr  = $urandom;
      wdata = $urandom;
      idx   = mdlIdx(addr);
      trap  = mdlTrap(size, addr);
      expR  = lastR;
      if (trap) begin
        expLat = 1; expReads = 0; expWrites = 0;
      end else if (we) begin
        expLat    = (size >= 2'd2) ? 2 : 3;
        expReads  = (size >= 2'd2) ? 0 : 1;
        expWrites = 1;
        refMem[idx] = mdlStore(refMem[idx], size, addr, wdata);
      end else begin
        expLat = 2; expReads = 1; expWrites = 0;
        expR   = mdlLoad(refMem[idx], size, uns, addr);
      end
      runOp(we, size, uns, addr, wdata, lat, reads, writes, err, busyOk, rdata, clean);
      check($sformatf("rnd%0d latency", n), 32'(lat), 32'(expLat));
      check($sformatf("rnd%0d rdata", n), rdata, expR);
      check($sformatf("rnd%0d err", n), 32'(err), 32'(trap));
      check($sformatf("rnd%0d reads", n), 32'(reads), 32'(expReads));
      check($sformatf("rnd%0d writes", n), 32'(writes), 32'(expWrites));
      check($sformatf("rnd%0d idle after done", n), 32'(clean & busyOk), 32'h1);
      lastR = expR;
    end

    for (int i = 0; i < MEM_WORDS; i++)
      check($sformatf("final mem[%0d]", i), mem[i], refMem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
